// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter granting N_REQ requesters access to one shared shift/normalise unit.
// Optional watchdog abort of a hung unit is built when ARB_TIMEOUT_EN is defined.
module shift_unit_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      unit_start,
  output logic [DATA_W-1:0]         unit_data,
  input  logic                      unit_done,
  input  logic [DATA_W-1:0]         unit_result,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [N_REQ-1:0] win_onehot;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W:0]   cand_sum;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;
  assign timeout_err = timeout_q;
`else
  // Watchdog not built; TIMEOUT is referenced only so the parameter list stays uniform.
  assign timeout_err = (TIMEOUT == 0) & 1'b0;
`endif

  // Search upward from the priority pointer, wrapping at N_REQ-1; first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand_sum >= (IDX_W+1)'(N_REQ)) begin
        cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
      end
      if (!win_found && req[cand_sum[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand_sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = win_found;
  end

  assign ptr_next = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_idx    <= '0;
      gnt        <= '0;
      unit_start <= 1'b0;
      unit_data  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      busy       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A still-asserted unit_done belongs to the previous job; hold off until it drops.
          if (win_found && !unit_done) begin
            gnt        <= win_onehot;
            gnt_idx    <= win_idx;
            unit_data  <= req_data[win_idx*DATA_W +: DATA_W];
            unit_start <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          unit_start <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (unit_done) begin
            rsp_valid <= gnt;
            rsp_data  <= unit_result;
            state     <= RESP;
`ifdef ARB_TIMEOUT_EN
            wd_cnt    <= '0;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            rsp_valid <= gnt;
            rsp_data  <= '0;
            timeout_q <= 1'b1;
            wd_cnt    <= '0;
            state     <= RESP;
          end else begin
            wd_cnt    <= wd_cnt + WD_W'(1);
`endif
          end
        end
        RESP: begin
          rsp_valid <= '0;
          gnt       <= '0;
          ptr       <= ptr_next;
          busy      <= 1'b0;
          state     <= IDLE;
`ifdef ARB_TIMEOUT_EN
          timeout_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Scoreboard bench for shift_unit_arbiter: round-robin reference model, behavioural shift unit,
// directed corner cases then randomized traffic; watchdog case runs when ARB_TIMEOUT_EN is defined.
module tb_shift_unit_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 16;
  localparam int unsigned TMO = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic           unit_start;
  logic [W-1:0]   unit_data;
  logic           unit_done = 1'b0;
  logic [W-1:0]   unit_result = '0;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic           timeout_err;

  shift_unit_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .unit_start(unit_start), .unit_data(unit_data), .unit_done(unit_done),
    .unit_result(unit_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic [W-1:0] data;
    logic [W-1:0] res;
    logic         tmo;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc = 0;
  logic        done_at_edge = 1'b0;
  int unsigned mptr = 0;
  logic [W-1:0] d [N];

  // Unit model controls
  int unsigned u_lat  = 3;
  int unsigned u_hold = 1;
  bit          u_mute = 1'b0;
  int unsigned done_rise_cyc = 0;

  function automatic logic [W-1:0] rotl4(input logic [W-1:0] x);
    return {x[W-5:0], x[W-1:W-4]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: required event absent or unexpected (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) begin
    cyc++;
    done_at_edge = unit_done;
  end

  // Behavioural shared unit: rotates the operand left by 4 after u_lat cycles, holds done u_hold cycles.
  int unsigned u_state = 0;
  int unsigned u_cnt   = 0;
  logic [W-1:0] u_res  = '0;
  always @(negedge clk) begin
    if (!rst) begin
      u_state   = 0;
      unit_done = 1'b0;
    end else begin
      case (u_state)
        0: if (unit_start && !u_mute) begin
          u_res   = rotl4(unit_data);
          u_cnt   = u_lat;
          u_state = 1;
        end
        1: begin
          u_cnt--;
          if (u_cnt == 0) begin
            unit_done     = 1'b1;
            unit_result   = u_res;
            done_rise_cyc = cyc + 1;
            u_cnt         = u_hold;
            u_state       = 2;
          end
        end
        default: begin
          u_cnt--;
          if (u_cnt == 0) begin
            unit_done   = 1'b0;
            unit_result = W'($urandom);
            u_state     = 0;
          end
        end
      endcase
    end
  end

  // Monitor: compares every start and response against the scoreboard head.
  bit          have_start = 1'b0;
  int unsigned last_start = 0;
  always @(negedge clk) begin
    exp_t e;
    int unsigned exp_cyc;
    if (!rst) begin
      have_start = 1'b0;
    end else begin
      if (unit_start) begin
        check("start_while_done_high", done_at_edge, 0);
        check("busy_at_start", busy, 1);
        if (have_start) check("start_spacing_ge4", (cyc - last_start) >= 4, 1);
        last_start = cyc;
        have_start = 1'b1;
        if (sb.size() == 0) fail_now("unexpected_start");
        else begin
          check("gnt", gnt, sb[0].gnt);
          check("unit_data", unit_data, sb[0].data);
        end
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) fail_now("unexpected_rsp");
        else begin
          e = sb.pop_front();
          check("rsp_valid", rsp_valid, e.gnt);
          check("rsp_data", rsp_data, e.res);
          check("timeout_err", timeout_err, e.tmo);
          check("gnt_held", gnt, e.gnt);
          check("unit_data_held", unit_data, e.data);
          exp_cyc = e.tmo ? last_start + TMO + 1 : done_rise_cyc;
          check("rsp_latency", cyc, exp_cyc);
        end
      end
    end
  end

  // Reference arbitration: first requester at or after the model pointer, wrapping.
  task automatic issue(input logic [N-1:0] mask, input bit mute, output int waited);
    exp_t e;
    int w;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(mptr) + k) % N;
      if (w < 0 && mask[idx]) w = idx;
    end
    req_data = {d[3], d[2], d[1], d[0]};
    req      = mask;
    u_mute   = mute;
    e.gnt  = N'(1) << w;
    e.data = d[w];
    e.res  = mute ? '0 : rotl4(d[w]);
    e.tmo  = mute;
    sb.push_back(e);
    mptr = (w + 1) % N;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!unit_start && waited < 300);
    if (!unit_start) fail_now("start_timeout");
  endtask

  task automatic finish_txn(input bit drop);
    int n;
    if (drop) begin
      req      = '0;
      req_data = {$urandom, $urandom};
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == '0 && n < 300);
    if (rsp_valid == '0) fail_now("rsp_timeout");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_ctrl_outs", {gnt, unit_start, rsp_valid, busy, timeout_err}, 0);
    check("rst_unit_data", unit_data, 0);
    check("rst_rsp_data", rsp_data, 0);
    req = '0;
    sb.delete();
    mptr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int waited;
    pulse_reset();
    @(negedge clk);
    check("idle_after_reset", {gnt, unit_start, rsp_valid, busy, timeout_err}, 0);

    // Single request from index 2, 10-cycle unit
    for (int i = 0; i < N; i++) d[i] = W'($urandom);
    d[2] = 16'h00F0;
    u_lat = 10; u_hold = 1;
    issue(4'b0100, 1'b0, waited);
    check("grant_latency", waited, 1);
    finish_txn(1'b0);
    req = '0;

    // Reset while in WAIT, then first grant follows pointer 0
    d[2] = 16'hA5A5;
    u_lat = 30;
    issue(4'b0100, 1'b0, waited);
    repeat (3) @(negedge clk);
    pulse_reset();
    u_lat = 4;
    for (int i = 0; i < N; i++) d[i] = W'($urandom);
    issue(4'b1010, 1'b0, waited);
    check("grant_latency_post_rst", waited, 1);
    finish_txn(1'b0);
    req = '0;

    // All requesters held: strict rotation 0,1,2,3,0
    pulse_reset();
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < N; i++) d[i] = W'($urandom);
      u_lat = 1 + (t % 3);
      issue(4'b1111, 1'b0, waited);
      finish_txn(1'b0);
    end

    // Index 1 drops its request during WAIT
    u_lat = 6;
    issue(4'b0010, 1'b0, waited);
    finish_txn(1'b1);

    // unit_done held after the response blocks the next grant
    u_lat = 2; u_hold = 4;
    issue(4'b0001, 1'b0, waited);
    finish_txn(1'b0);
    u_hold = 1;
    issue(4'b0001, 1'b0, waited);
    check("done_block_wait", waited, 4);
    finish_txn(1'b0);
    req = '0;

`ifdef ARB_TIMEOUT_EN
    // Unit never answers: watchdog response
    issue(4'b1000, 1'b1, waited);
    finish_txn(1'b0);
    u_mute = 1'b0;
    req = '0;
`endif

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) d[i] = W'($urandom);
      u_lat  = $urandom_range(1, 12);
      u_hold = $urandom_range(1, 5);
      issue(mask, 1'b0, waited);
      finish_txn(($urandom % 2) == 1);
      if (($urandom % 4) == 0) begin
        req = '0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end

    req = '0;
    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_unit_arbiter.md
SHIFT_UNIT_ARBITER -- requirements
Module: shift_unit_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one shift/normalise unit (2..8).
REQ-002 Parameter DATA_W, default 16: operand and result width.
REQ-003 Parameter TIMEOUT, default 64: watchdog limit in cycles (used only with ARB_TIMEOUT_EN).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 req  input  N_REQ  per-requester operation request, level.
REQ-007 req_data  input  N_REQ*DATA_W  per-requester operand; slice i = bits [i*DATA_W +: DATA_W].
REQ-008 gnt  output  N_REQ  one-hot grant; held for the whole transaction.
REQ-009 unit_start  output  1  start pulse to the shared unit's controller.
REQ-010 unit_data  output  DATA_W  operand presented to the unit.
REQ-011 unit_done  input  1  unit completion, level.
REQ-012 unit_result  input  DATA_W  unit result, valid while unit_done = 1.
REQ-013 rsp_valid  output  N_REQ  one-cycle one-hot response pulse to the granted requester.
REQ-014 rsp_data  output  DATA_W  response data, valid with rsp_valid.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 timeout_err  output  1  one-cycle pulse with a watchdog-aborted response.

Function
REQ-017 FSM states IDLE, START, WAIT, RESP; all outputs registered.
REQ-018 IDLE -> START when any req bit = 1 and unit_done = 0; the winner is captured into gnt and its req_data into an operand register.
REQ-019 IDLE with unit_done = 1 stays in IDLE (no new grant while the unit still reports a prior completion).
REQ-020 Arbitration is round-robin: a priority pointer names the highest-priority index; search ascends from the pointer with wrap from N_REQ-1 to 0.
REQ-021 START: unit_start = 1 for exactly one cycle, unit_data = operand register; next state WAIT.
REQ-022 WAIT: on first cycle with unit_done = 1, latch unit_result and go to RESP; otherwise remain.
REQ-023 RESP: rsp_valid = gnt for one cycle, rsp_data = latched result; pointer <- (granted index + 1) mod N_REQ; next state IDLE with gnt cleared.
REQ-024 Latency: req seen in IDLE at edge t -> gnt and unit_start high after edge t+1; rsp_valid high one cycle after unit_done is sampled.
REQ-025 Requester dropping req after grant does not abort; the transaction completes and rsp_valid is still pulsed.
REQ-026 req/req_data changes after capture do not affect unit_data.
REQ-027 Minimum spacing between two unit_start pulses is 4 cycles; back-to-back requests from all requesters are served strictly in rotation.
REQ-028 unit_data and rsp_data hold their last values outside their valid cycles.

Reset
REQ-029 rst = 0 forces, asynchronously, state IDLE, pointer 0, gnt = 0, unit_start = 0, unit_data = 0, rsp_valid = 0, rsp_data = 0, busy = 0, timeout_err = 0, watchdog count = 0.
REQ-030 Reset mid-transaction discards it with no response; the first grant after release follows pointer 0.

Configuration
REQ-031 Macro ARB_TIMEOUT_EN defined: a counter runs in WAIT; if unit_done is not seen within TIMEOUT cycles of entering WAIT, go to RESP with rsp_data = 0 and timeout_err = 1 for that RESP cycle; pointer advances normally.
REQ-032 Macro ARB_TIMEOUT_EN undefined: WAIT persists indefinitely, no counter is built, timeout_err is constant 0.

Verification
REQ-033 Reset, req = 4'b0100, data2 = 16'h00F0, unit returns 16'h0F00 after 10 cycles -> gnt = 4'b0100, one unit_start, unit_data = 16'h00F0, rsp_valid = 4'b0100 with rsp_data = 16'h0F00.
REQ-034 req = 4'b1111 held for 4 transactions after reset -> grant order 0,1,2,3, then 0 again.
REQ-035 Grant to 1, then req[1] dropped during WAIT -> rsp_valid[1] still pulses once.
REQ-036 unit_done held high 3 cycles after response with req = 4'b0001 -> no unit_start until unit_done falls.
REQ-037 rst pulled low during WAIT -> all outputs 0 immediately; after release, req = 4'b1010 grants index 1.
REQ-038 ARB_TIMEOUT_EN, TIMEOUT = 64, unit_done never asserted -> rsp_valid and timeout_err pulse 64 cycles after entering WAIT, rsp_data = 0.
